// File: rtl/window_sequencer_if.sv
// Handshake bundle between the window sequencer and its controller.
// master: the sequencer side; slave: the controller/consumer side.
interface window_sequencer_if;
    logic       start;
    logic       stall;
    logic       en;
    logic       clear;
    logic       new_row;
    logic       new_vector;
    logic [1:0] quadrant;
    logic       quadrant_lsb;
    logic [3:0] row_index;
    logic [3:0] col_base;
    logic       done;
    logic [7:0] cycle_count;

    modport master (
        input  start,
        input  stall,
        output en,
        output clear,
        output new_row,
        output new_vector,
        output quadrant,
        output quadrant_lsb,
        output row_index,
        output col_base,
        output done,
        output cycle_count
    );

    modport slave (
        output start,
        output stall,
        input  en,
        input  clear,
        input  new_row,
        input  new_vector,
        input  quadrant,
        input  quadrant_lsb,
        input  row_index,
        input  col_base,
        input  done,
        input  cycle_count
    );
endinterface

// File: rtl/window_sequencer.sv
// 3x3 window read sequencer over a 12x12 image split into four 6x6 quadrants.
// Optional RUN-cycle counter: define WINDOW_SEQ_CYCLE_COUNT_EN.
module window_sequencer (
    input  logic                clock,
    input  logic                reset,
    window_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] col_off;
    logic [1:0] row_off;
    logic [1:0] win;

    logic [1:0] col_n;
    logic [1:0] row_n;
    logic [1:0] win_n;
    logic [1:0] q_inc;
    logic       last;

    function automatic logic [3:0] row_of(
        input logic       q1,
        input logic       w1,
        input logic [1:0] r
    );
        return (q1 ? 4'd6 : 4'd0) + (w1 ? 4'd3 : 4'd0) + {2'b00, r};
    endfunction

    function automatic logic [3:0] col_of(
        input logic q0,
        input logic w0
    );
        return (q0 ? 4'd6 : 4'd0) + (w0 ? 4'd3 : 4'd0);
    endfunction

    // Counters name the element on the bus; they advance only past an en cycle.
    always_comb begin
        col_n = col_off;
        row_n = row_off;
        win_n = win;
        if (bus.en) begin
            if (col_off == 2'd2) begin
                col_n = 2'd0;
                if (row_off == 2'd2) begin
                    row_n = 2'd0;
                    win_n = win + 2'd1;
                end else begin
                    row_n = row_off + 2'd1;
                end
            end else begin
                col_n = col_off + 2'd1;
            end
        end
    end

    assign last  = (col_off == 2'd2) && (row_off == 2'd2) && (win == 2'd3);
    assign q_inc = bus.quadrant + 2'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            col_off          <= '0;
            row_off          <= '0;
            win              <= '0;
            bus.en           <= 1'b0;
            bus.clear        <= 1'b0;
            bus.new_row      <= 1'b0;
            bus.new_vector   <= 1'b0;
            bus.quadrant     <= '0;
            bus.quadrant_lsb <= 1'b0;
            bus.row_index    <= '0;
            bus.col_base     <= '0;
            bus.done         <= 1'b0;
        end else begin
            bus.en         <= 1'b0;
            bus.clear      <= 1'b0;
            bus.new_row    <= 1'b0;
            bus.new_vector <= 1'b0;
            bus.done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state            <= CLEAR;
                        bus.clear        <= 1'b1;
                        bus.quadrant     <= 2'd0;
                        bus.quadrant_lsb <= 1'b0;
                        bus.row_index    <= 4'd0;
                        bus.col_base     <= 4'd0;
                    end
                end
                CLEAR: begin
                    state         <= RUN;
                    col_off       <= '0;
                    row_off       <= '0;
                    win           <= '0;
                    bus.en        <= 1'b1;
                    bus.row_index <= row_of(bus.quadrant[1], 1'b0, 2'd0);
                    bus.col_base  <= col_of(bus.quadrant[0], 1'b0);
                end
                RUN: begin
                    if (bus.en && last) begin
                        if (bus.quadrant == 2'd3) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state            <= CLEAR;
                            bus.clear        <= 1'b1;
                            bus.quadrant     <= q_inc;
                            bus.quadrant_lsb <= q_inc[0];
                            bus.row_index    <= row_of(q_inc[1], 1'b0, 2'd0);
                            bus.col_base     <= col_of(q_inc[0], 1'b0);
                        end
                    end else begin
                        col_off        <= col_n;
                        row_off        <= row_n;
                        win            <= win_n;
                        bus.en         <= !bus.stall;
                        bus.new_row    <= !bus.stall && (col_n == 2'd2);
                        bus.new_vector <= !bus.stall && (col_n == 2'd2)
                                          && (row_n == 2'd2);
                        bus.row_index  <= row_of(bus.quadrant[1], win_n[1], row_n);
                        bus.col_base   <= col_of(bus.quadrant[0], win_n[0]);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.cycle_count <= '0;
        end else if (state == IDLE && bus.start) begin
            bus.cycle_count <= '0;
        end else if (state == RUN && bus.cycle_count != 8'hFF) begin
            bus.cycle_count <= bus.cycle_count + 8'd1;
        end
    end
`else
    assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_window_sequencer.sv
// Randomized self-checking bench for window_sequencer.
// Reference model tracks element index per quadrant, not the RTL counters.
module tb_window_sequencer;

    localparam int S_IDLE  = 0;
    localparam int S_CLEAR = 1;
    localparam int S_RUN   = 2;
    localparam int S_DONE  = 3;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    window_sequencer_if bus();

    window_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int m_st, m_q, m_e, m_en, m_cnt, m_row, m_col;

    int done_cyc, done_cnt;
    int n_clr, n_en, n_row, n_vec, n_done;
    int first_q, first_row;
    int q1_n;
    int q1_row [9];
    int q1_col [9];
    int q1_nr  [9];
    int q1_nv  [9];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = S_IDLE;
        m_q   = 0;
        m_e   = 0;
        m_en  = 0;
        m_cnt = 0;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_step(input logic st, input logic sl);
        case (m_st)
            S_IDLE: begin
                if (st) begin
                    m_st  = S_CLEAR;
                    m_q   = 0;
                    m_cnt = 0;
                end
            end
            S_CLEAR: begin
                m_st = S_RUN;
                m_e  = 0;
                m_en = 1;
            end
            S_RUN: begin
                if (m_cnt < 255) m_cnt++;
                if (m_en != 0 && m_e == 35) begin
                    m_en = 0;
                    if (m_q == 3) begin
                        m_st = S_DONE;
                    end else begin
                        m_q++;
                        m_st = S_CLEAR;
                    end
                end else begin
                    if (m_en != 0) m_e++;
                    m_en = sl ? 0 : 1;
                end
            end
            default: m_st = S_IDLE;
        endcase
        if (m_st == S_CLEAR) begin
            m_row = 6 * (m_q / 2);
            m_col = 6 * (m_q % 2);
        end
        if (m_st == S_RUN) begin
            m_row = 6 * (m_q / 2) + 3 * ((m_e / 9) / 2) + (m_e % 9) / 3;
            m_col = 6 * (m_q % 2) + 3 * ((m_e / 9) % 2);
        end
    endtask

    task automatic compare_all();
        int en_e;
        en_e = (m_st == S_RUN && m_en != 0) ? 1 : 0;
        chk("en", bus.en, en_e);
        chk("clear", bus.clear, m_st == S_CLEAR);
        chk("done", bus.done, m_st == S_DONE);
        chk("new_row", bus.new_row, en_e != 0 && (m_e % 3) == 2);
        chk("new_vector", bus.new_vector, en_e != 0 && (m_e % 9) == 8);
        chk("quadrant", bus.quadrant, m_q);
        chk("quadrant_lsb", bus.quadrant_lsb, m_q % 2);
        chk("row_index", bus.row_index, m_row);
        chk("col_base", bus.col_base, m_col);
`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
        chk("cycle_count", bus.cycle_count, m_cnt);
`else
        chk("cycle_count", bus.cycle_count, 0);
`endif
    endtask

    task automatic do_cycle(input logic st, input logic sl);
        bus.start = st;
        bus.stall = sl;
        @(posedge clock);
        if (reset) model_reset();
        else model_step(st, sl);
        #1;
        compare_all();
    endtask

    task automatic run_pass(input int mode, input logic hold);
        int   cyc;
        logic sl;
        done_cyc = 0;
        done_cnt = 0;
        n_clr    = 0;
        n_en     = 0;
        n_row    = 0;
        n_vec    = 0;
        n_done   = 0;
        q1_n     = 0;
        do_cycle(1'b1, 1'b0);
        first_q   = bus.quadrant;
        first_row = bus.row_index;
        cyc = 1;
        while (cyc < 400) begin
            n_clr  += bus.clear;
            n_en   += bus.en;
            n_row  += bus.new_row;
            n_vec  += bus.new_vector;
            n_done += bus.done;
            if (bus.quadrant == 2'd1 && bus.en && q1_n < 9) begin
                q1_row[q1_n] = bus.row_index;
                q1_col[q1_n] = bus.col_base;
                q1_nr[q1_n]  = bus.new_row;
                q1_nv[q1_n]  = bus.new_vector;
                q1_n++;
            end
            if (bus.done) begin
                done_cyc = cyc;
                done_cnt = bus.cycle_count;
                break;
            end
            sl = 1'b0;
            if (mode == 1) sl = (cyc >= 10 && cyc < 15);
            if (mode == 2) sl = ($urandom_range(0, 3) == 0);
            do_cycle(hold, sl);
            cyc++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        reset     = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        reset = 1'b0;

        do_cycle(1'b0, 1'b0);
        do_cycle(1'b0, 1'b1);
        do_cycle(1'b0, 1'b1);

        run_pass(0, 1'b0);
        chk("p1_done_cyc", done_cyc, 149);
        chk("p1_clear", n_clr, 4);
        chk("p1_en", n_en, 144);
        chk("p1_new_row", n_row, 48);
        chk("p1_new_vec", n_vec, 16);
        chk("p1_done_n", n_done, 1);
        chk("q1_n", q1_n, 9);
        for (int i = 0; i < 9; i++) begin
            chk("q1_row", q1_row[i], i / 3);
            chk("q1_col", q1_col[i], 6);
            chk("q1_nr", q1_nr[i], (i % 3) == 2);
            chk("q1_nv", q1_nv[i], i == 8);
        end
        do_cycle(1'b0, 1'b0);

        run_pass(1, 1'b0);
        chk("p2_done_cyc", done_cyc, 154);
        chk("p2_en", n_en, 144);
`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
        chk("p2_cnt", done_cnt, 149);
`else
        chk("p2_cnt", done_cnt, 0);
`endif
        do_cycle(1'b0, 1'b1);

        run_pass(2, 1'b0);
        chk("p3_en", n_en, 144);
        chk("p3_new_vec", n_vec, 16);
        chk("p3_done_n", n_done, 1);
        do_cycle(1'b0, 1'b0);

        do_cycle(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) do_cycle(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_en", bus.en, 0);
        chk("arst_quadrant", bus.quadrant, 0);
        chk("arst_row", bus.row_index, 0);
        chk("arst_col", bus.col_base, 0);
        chk("arst_cnt", bus.cycle_count, 0);
        model_reset();
        do_cycle(1'b1, 1'b0);
        do_cycle(1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b0);

        run_pass(0, 1'b0);
        chk("p4_first_q", first_q, 0);
        chk("p4_first_row", first_row, 0);
        chk("p4_done_cyc", done_cyc, 149);
        do_cycle(1'b0, 1'b0);

        run_pass(0, 1'b1);
        chk("p5_done_cyc", done_cyc, 149);
        chk("p5_clear", n_clr, 4);
        chk("p5_done_n", n_done, 1);
        do_cycle(1'b1, 1'b0);
        chk("p5_idle_clear", bus.clear, 0);
        do_cycle(1'b1, 1'b0);
        chk("p5_restart_clear", bus.clear, 1);
        do_cycle(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
